// File: rtl/plab2_proc_intr_agent.sv
// plab2_proc_intr_agent: queues core interrupt requests and runs the rq/ack/val handshake with the PIC.
// Define PLAB2_PROC_INTR_TIMEOUT_EN to enable the grant-wait timeout with sticky err and retry.
module plab2_proc_intr_agent #(
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       core_req_val,
  output logic       core_req_rdy,
  input  logic [3:0] core_req_id,
  input  logic       prio_hi,
  output logic       intr_rq,
  output logic       intr_set,
  input  logic       intr_ack,
  input  logic       intr_val,
  output logic       irq_val,
  output logic [3:0] irq_id,
  input  logic       irq_rdy,
  output logic       err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [2:0] {INIT, IDLE, REQ, WAITVAL, DELIVER} state_t;
  state_t state_q;
  logic [3:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic full, empty, push, pop;
  assign full         = count_q == CW'(FIFO_DEPTH);
  assign empty        = count_q == '0;
  assign core_req_rdy = state_q != INIT && !full;
  assign push         = core_req_val && core_req_rdy;
  assign pop          = irq_val && irq_rdy;
  assign intr_set     = state_q == INIT && prio_hi;
  assign intr_rq      = state_q == REQ;
  assign irq_val      = state_q == DELIVER;
  assign irq_id       = irq_val ? mem_q[head_q] : 4'h0;
  always_ff @(posedge clk)
    if (push) mem_q[tail_q] <= core_req_id;
  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk)
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop) head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
`ifdef PLAB2_PROC_INTR_TIMEOUT_EN
  logic [3:0] cnt_q;
  logic       err_q;
  assign err = err_q;
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else
      case (state_q)
        INIT:    state_q <= IDLE;
        IDLE:    if (!empty) state_q <= REQ;
        REQ:     if (intr_ack) begin
                   state_q <= WAITVAL;
                   cnt_q   <= '0;
                 end
        WAITVAL: if (intr_val) state_q <= DELIVER;
                 else if (cnt_q == 4'(TIMEOUT - 1)) begin
                   err_q   <= 1'b1;
                   state_q <= REQ;
                 end else cnt_q <= cnt_q + 1'b1;
        DELIVER: if (irq_rdy) state_q <= IDLE;
        default: state_q <= INIT;
      endcase
`else
  assign err = 1'b0;
  always_ff @(posedge clk)
    if (reset) state_q <= INIT;
    else
      case (state_q)
        INIT:    state_q <= IDLE;
        IDLE:    if (!empty) state_q <= REQ;
        REQ:     if (intr_ack) state_q <= WAITVAL;
        WAITVAL: if (intr_val) state_q <= DELIVER;
        DELIVER: if (irq_rdy) state_q <= IDLE;
        default: state_q <= INIT;
      endcase
`endif
endmodule
